// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - state encoding and sizing helper for the bit-serial subtractor
package sub_pkg;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] SHIFT_ENC = 2'd1;
  localparam logic [1:0] DONE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = IDLE_ENC,
    SHIFT = SHIFT_ENC,
    DONE  = DONE_ENC
  } state_t;

  function automatic int count_width(input int width);
    int w;
    w = $clog2(width + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_subtractor_nbit_if.sv
// rtl/serial_subtractor_nbit_if.sv - start/busy/done operand and result bundle
interface serial_subtractor_nbit_if #(
  parameter int BIT_WIDTH = 4
);

  logic                 start;
  logic [BIT_WIDTH-1:0] a;
  logic [BIT_WIDTH-1:0] b;
  logic                 busy;
  logic                 done;
  logic [BIT_WIDTH-1:0] difference;
  logic                 borrow;
  logic                 overflow;

  modport master (
    output start, a, b,
    input  busy, done, difference, borrow, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, difference, borrow, overflow
  );

endinterface

// File: rtl/adder_1bit.sv
// rtl/adder_1bit.sv - single full-adder cell
module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor_nbit.sv
// rtl/serial_subtractor_nbit.sv - bit-serial a - b, LSB first, one full adder on a + ~b + 1
module serial_subtractor_nbit
  import sub_pkg::*;
#(
  parameter int BIT_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_subtractor_nbit_if.slave   bus
);

  localparam int              CW   = count_width(BIT_WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(BIT_WIDTH - 1);

  state_t               state;
  logic [BIT_WIDTH-1:0] a_reg;
  logic [BIT_WIDTH-1:0] b_reg;
  logic [BIT_WIDTH-1:0] res_reg;
  logic [BIT_WIDTH-1:0] res_next;
  logic [BIT_WIDTH-1:0] difference_r;
  logic [CW-1:0]        count;
  logic                 carry;
  logic                 a_msb;
  logic                 b_msb;
  logic                 borrow_r;
  logic                 overflow_r;
  logic                 sum;
  logic                 cout;

  adder_1bit u_adder (
    .a    (a_reg[0]),
    .b    (~b_reg[0]),
    .cin  (carry),
    .sum  (sum),
    .cout (cout)
  );

  // Sum enters at the MSB so after BIT_WIDTH shifts the LSB has reached bit 0.
  generate
    if (BIT_WIDTH == 1) begin : g_res_one
      assign res_next = sum;
    end else begin : g_res_wide
      assign res_next = {sum, res_reg[BIT_WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      res_reg      <= '0;
      count        <= '0;
      carry        <= 1'b0;
      a_msb        <= 1'b0;
      b_msb        <= 1'b0;
      difference_r <= '0;
      borrow_r     <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            carry <= 1'b1;
            count <= '0;
            a_msb <= bus.a[BIT_WIDTH-1];
            b_msb <= bus.b[BIT_WIDTH-1];
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res_reg <= res_next;
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          carry   <= cout;
          count   <= count + CW'(1);
          // Results are published only here so they hold steady between operations.
          if (count == LAST) begin
            state        <= DONE;
            difference_r <= res_next;
            borrow_r     <= ~cout;
            overflow_r   <= (a_msb ^ b_msb) & (res_next[BIT_WIDTH-1] ^ a_msb);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state == SHIFT);
  assign bus.done       = (state == DONE);
  assign bus.difference = difference_r;
  assign bus.borrow     = borrow_r;
  assign bus.overflow   = overflow_r;

endmodule
